// File: rtl/fifo_read_drain.sv
// -----------------------------------------------------------------------------
// fifo_read_drain
//
// Purpose: drains a memory-core FIFO into a 4-entry skid buffer. Reads are
// issued only when a free buffer slot is guaranteed for every read still in
// flight, so returning words are never dropped. The read latency is not
// assumed; each valid_out is matched against the count of outstanding reads.
// A flush discards buffered words and absorbs any returns still in flight.
//
// Optional feature: define FIFO_READ_DRAIN_STATS_EN to add the 16-bit
// wrapping counters rd_issued_cnt (ren_in pulses) and rd_delivered_cnt
// (out_valid && out_ready handshakes).
//
// Ports:
//   clk              - single clock, rising edge
//   reset            - synchronous, active-high
//   drain_en         - allow reads to be issued to the memory core
//   flush            - abort draining, discard buffered and in-flight words
//   empty            - memory-core FIFO empty status
//   ren_in           - read enable to the memory core
//   valid_out        - memory-core read-data valid
//   data_out [15:0]  - memory-core read data
//   out_data [15:0]  - head word of the skid buffer
//   out_valid        - out_data holds a valid word
//   out_ready        - consumer accepts a word when out_valid && out_ready
//   err_unexp        - sticky: valid_out seen with no reads outstanding
//   state [1:0]      - 0 IDLE, 1 RUN, 2 FLUSH
//   rd_issued_cnt    - (stats build only) ren_in pulse count
//   rd_delivered_cnt - (stats build only) delivered word count
//
// Output handshake: a word transfers on any rising edge where
// out_valid && out_ready; out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module fifo_read_drain (
    input  logic        clk,
    input  logic        reset,
    input  logic        drain_en,
    input  logic        flush,
    input  logic        empty,
    output logic        ren_in,
    input  logic        valid_out,
    input  logic [15:0] data_out,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_unexp,
    output logic [1:0]  state
`ifdef FIFO_READ_DRAIN_STATS_EN
    ,
    output logic [15:0] rd_issued_cnt,
    output logic [15:0] rd_delivered_cnt
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic [2:0]  outst;
    logic [2:0]  occ;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [15:0] buf_mem [4];
    logic [3:0]  inflight;
    logic        ret_ok;
    logic        unexp;
    logic        flush_entry;
    logic        push;
    logic        pop;

    // Reads outstanding plus words held: a read may only be issued while this
    // is below the buffer depth, which reserves a slot for every return.
    assign inflight    = {1'b0, outst} + {1'b0, occ};
    assign ren_in      = !reset && (state_q == ST_RUN) && !empty && (inflight < 4'd4);

    assign ret_ok      = valid_out && (outst != 3'd0);
    assign unexp       = valid_out && (outst == 3'd0);
    assign flush_entry = flush && (state_q != ST_FLUSH);
    // Returns are buffered in IDLE and RUN; in FLUSH (and on the flush entry
    // cycle itself) they only retire the outstanding count.
    assign push        = ret_ok && (state_q != ST_FLUSH) && !flush_entry;

    assign out_valid   = !reset && (occ != 3'd0);
    assign out_data    = reset ? 16'h0000 : buf_mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign state       = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush)         state_d = ST_FLUSH;
                else if (drain_en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush)         state_d = ST_FLUSH;
                else if (!drain_en) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if ((outst == 3'd0) && !flush) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            outst     <= 3'd0;
            occ       <= 3'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            err_unexp <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                buf_mem[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            // Issue and return in the same cycle cancel out.
            outst   <= outst + {2'b00, ren_in} - {2'b00, ret_ok};
            if (unexp) begin
                err_unexp <= 1'b1;
            end
            if (flush_entry) begin
                occ    <= 3'd0;
                wr_ptr <= 2'd0;
                rd_ptr <= 2'd0;
            end else begin
                occ <= occ + {2'b00, push} - {2'b00, pop};
                if (push) begin
                    buf_mem[wr_ptr] <= data_out;
                    wr_ptr          <= wr_ptr + 2'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                end
            end
        end
    end

`ifdef FIFO_READ_DRAIN_STATS_EN
    // Not cleared by flush; wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_issued_cnt    <= 16'h0000;
            rd_delivered_cnt <= 16'h0000;
        end else begin
            if (ren_in) rd_issued_cnt    <= rd_issued_cnt + 16'h0001;
            if (pop)    rd_delivered_cnt <= rd_delivered_cnt + 16'h0001;
        end
    end
`endif

endmodule
